dmem_access_unit: RTL
=====================

# dmem_access_unit

Memory-stage front end of the RISC-V core. Takes one load/store request at a time from the execute stage, word-aligns the address, generates store byte-enables and lane-replicated write data, and runs a valid/ready request plus response-wait handshake with data memory / MMIO. For loads it captures the raw 32-bit word, byte offset and funct3 that the downstream load-extension stage consumes, and emits a one-cycle completion pulse.

## Interface
- `ADDR_W`, 32, address width (data width fixed at 32)
- `clk` in 1: core clock
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: execute stage presents an access
- `req_ready` out 1: unit can accept; high only in IDLE
- `req_we` in 1: 1 = store, 0 = load
- `req_funct3` in 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `req_addr` in ADDR_W: byte address
- `req_wdata` in 32: unshifted rs2
- `mem_req_valid` out 1: memory request pending
- `mem_req_ready` in 1: memory accepts the request
- `mem_addr` out ADDR_W: word address, [1:0] = 00
- `mem_wdata` out 32: lane-replicated store data
- `mem_wbe` out 4: byte enables, 0000 for loads
- `mem_rsp_valid` in 1: load data valid
- `mem_rdata` in 32: load word
- `ld_valid` out 1: one-cycle pulse, load data ready
- `ld_data` out 32: captured raw word
- `ld_sel` out 2: captured addr[1:0]
- `ld_funct3` out 3: captured funct3
- `st_done` out 1: one-cycle pulse, store accepted by memory
- `misalign` out 1: one-cycle pulse, misaligned access dropped (macro only)
- `busy` out 1: state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE: `req_ready`=1. On `req_valid`: register we/funct3/addr, compute `mem_wbe`/`mem_wdata`, go to ISSUE.
- ISSUE: `mem_req_valid`=1; addr/wdata/wbe held stable. On `mem_req_ready`, a store pulses `st_done` next cycle and returns to IDLE (posted, no response); a load goes to WAIT_RSP.
- WAIT_RSP: on `mem_rsp_valid`, capture `mem_rdata` into `ld_data`, pulse `ld_valid` next cycle, return to IDLE.
- `mem_rsp_valid` is ignored in IDLE and ISSUE.
- Store lanes: B: wbe = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}. H: wbe = 0011 << {addr[1],0}, wdata = {2{wdata[15:0]}}. W: wbe = 1111, wdata unchanged.
- Illegal funct3 (011, 110, 111; 100/101 with we=1) is treated as W (010).
- `ld_data`/`ld_sel`/`ld_funct3` hold until the next load is captured.
- Reset: async to IDLE. All outputs 0 except `req_ready`=1. A response arriving after reset is ignored.

## Timing
- Request accepted at edge 0. `mem_req_valid` is high from cycle 1 until `mem_req_ready`.
- Store with zero-wait memory: `st_done` at cycle 2.
- Load: response is no earlier than 1 cycle after `mem_req_ready`. `ld_valid` is high the cycle after `mem_rsp_valid`; minimum accept-to-`ld_valid` is 3 cycles.
- A new request can be accepted in the same cycle `ld_valid` or `st_done` pulses.
- Memory must not assert `mem_rsp_valid` in the same cycle as `mem_req_ready`.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: H with addr[0]=1, or W with addr[1:0]!=0, is accepted but never issued. `misalign` pulses the cycle after accept, and the FSM returns to IDLE with no `st_done`/`ld_valid`.
- Undefined: `misalign` is tied 0. The access is issued at the word address; H lane is selected by addr[1], and W ignores addr[1:0].

## Structure
- Shared package `riscv_mem_pkg`: funct3 localparams (LB/LH/LW/LBU/LHU/SB/SH/SW) and FSM state encoding. The downstream load-extension stage uses the same constants.
- One combinational sub-module `store_align`: (funct3, addr[1:0], wdata) -> (wbe, wdata), used by the FSM wrapper.

## Test plan
- SB addr 0x1003, wdata 0x000000A5, ready=1 -> mem_addr 0x1000, wbe 1000, wdata 0xA5A5A5A5; single `st_done` at cycle 2.
- SH addr 0x2002, wdata 0x1234BEEF -> wbe 1100, wdata 0xBEEFBEEF.
- LBU addr 0x3001, `mem_rdata` 0xDEADBEEF after 3 wait cycles -> exactly one `ld_valid`; ld_data 0xDEADBEEF, ld_sel 01, ld_funct3 100; `req_ready` low until then.
- `mem_req_ready` held low 5 cycles on an SW -> mem_req_valid/addr/wdata/wbe stable throughout; wbe 1111.
- LW addr 0x4002 -> with macro: `misalign` pulse, no `mem_req_valid`. Without macro: mem_addr 0x4000 issued, `misalign`=0.
- `rst_n` low during WAIT_RSP, then a late `mem_rsp_valid` -> outputs 0 immediately, no `ld_valid`, state IDLE.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: constants shared by the memory-stage front end and the
// downstream load-extension stage.
//   - funct3 encodings for loads/stores
//   - dmem_access_unit FSM state encoding
//   - norm_funct3(): maps illegal funct3 codes onto a full word access
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  // Anything that is not a legal width for the access direction becomes a word.
  function automatic logic [2:0] norm_funct3(input logic we, input logic [2:0] f3);
    logic [2:0] r;
    r = we ? F3_SW : F3_LW;
    if (we) begin
      if (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW) r = f3;
    end else begin
      if (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU) r = f3;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_access_unit_store_align.sv
// store_align: combinational store lane steering.
//   funct3_i  : normalized store funct3 (SB/SH/SW)
//   addr_lo_i : byte offset addr[1:0]
//   wdata_i   : unshifted rs2
//   wbe_o     : byte enables
//   wdata_o   : data replicated across all lanes of the access width
module store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wbe_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    wbe_o   = 4'b1111;
    wdata_o = wdata_i;
    if (funct3_i == F3_SB) begin
      wbe_o   = 4'b0001 << addr_lo_i;
      wdata_o = {4{wdata_i[7:0]}};
    end else if (funct3_i == F3_SH) begin
      // Halfword lane is picked by addr[1] only; addr[0] is ignored here.
      wbe_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
      wdata_o = {2{wdata_i[15:0]}};
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage front end. Accepts one load/store at a time,
// issues a word-aligned request to data memory, waits for load data and
// captures it (raw word, byte offset, funct3) for the load-extension stage.
//   req_*      : execute-stage request (valid/ready)
//   mem_req_*  : memory request, mem_addr/mem_wdata/mem_wbe held while pending
//   mem_rsp_*  : load response, only honoured while waiting for one
//   ld_*       : captured load result, ld_valid is a one-cycle pulse
//   st_done    : one-cycle pulse after a store is accepted by memory
//   misalign   : one-cycle pulse for a dropped misaligned access
//   busy       : FSM not idle
// Build option: define DMEM_MISALIGN_TRAP_EN to drop misaligned H/W accesses
// and report them on misalign; otherwise misalign is 0 and they are issued.
module dmem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wbe,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rdata,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic [1:0]        ld_sel,
  output logic [2:0]        ld_funct3,
  output logic              st_done,
  output logic              misalign,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wbe_q, wbe_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic [1:0]        ld_sel_q, ld_sel_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic              ld_valid_q, ld_valid_d;
  logic              st_done_q, st_done_d;

  logic [2:0]        f3_n;
  logic [3:0]        sa_wbe;
  logic [31:0]       sa_wdata;

  assign f3_n = norm_funct3(req_we, req_funct3);

  store_align u_store_align (
    .funct3_i  (f3_n),
    .addr_lo_i (req_addr[1:0]),
    .wdata_i   (req_wdata),
    .wbe_o     (sa_wbe),
    .wdata_o   (sa_wdata)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis, misalign_q, misalign_d;
  // Low two funct3 bits give the width for both loads and stores after normalization.
  assign mis = ((f3_n[1:0] == 2'b01) && req_addr[0]) ||
               ((f3_n[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wbe_d      = wbe_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    ld_sel_d   = ld_sel_q;
    ld_f3_d    = ld_f3_q;
    ld_valid_d = 1'b0;
    st_done_d  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = f3_n;
          sel_d   = req_addr[1:0];
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          wbe_d   = req_we ? sa_wbe : 4'b0000;
          wdata_d = req_we ? sa_wdata : 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (mis) misalign_d = 1'b1;
          else     state_d    = ST_ISSUE;
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          // Stores are posted: no response is expected from memory.
          if (we_q) begin
            st_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          ld_data_d  = mem_rdata;
          ld_sel_d   = sel_q;
          ld_f3_d    = f3_q;
          ld_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      sel_q      <= 2'b00;
      addr_q     <= '0;
      wbe_q      <= 4'b0000;
      wdata_q    <= 32'h0;
      ld_data_q  <= 32'h0;
      ld_sel_q   <= 2'b00;
      ld_f3_q    <= 3'b000;
      ld_valid_q <= 1'b0;
      st_done_q  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wbe_q      <= wbe_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      ld_sel_q   <= ld_sel_d;
      ld_f3_q    <= ld_f3_d;
      ld_valid_q <= ld_valid_d;
      st_done_q  <= st_done_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wbe       = wbe_q;
  assign ld_valid      = ld_valid_q;
  assign ld_data       = ld_data_q;
  assign ld_sel        = ld_sel_q;
  assign ld_funct3     = ld_f3_q;
  assign st_done       = st_done_q;

endmodule
